// File: rtl/coe_buf_rd_ctrl_pkg.sv
// Shared definitions for the coefficient-buffer read controller: sample width,
// TU size encodings, FSM states and the TU word-count helper.
package coe_buf_rd_ctrl_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int IDX_W       = 7;

    typedef enum logic [1:0] {
        TU_4X4   = 2'd0,
        TU_8X8   = 2'd1,
        TU_16X16 = 2'd2,
        TU_32X32 = 2'd3
    } tu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index of the final word of a TU (NxN samples, 8 samples per word, minus one).
    function automatic logic [IDX_W-1:0] tu_last_idx(input logic [1:0] tu_size);
        logic [IDX_W-1:0] idx;
        idx = '0;
        case (tu_size_e'(tu_size))
            TU_4X4:   idx = 7'd1;
            TU_8X8:   idx = 7'd7;
            TU_16X16: idx = 7'd31;
            TU_32X32: idx = 7'd127;
            default:  idx = 7'd1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/coe_buf_rd_fifo.sv
// Small synchronous skid FIFO sitting between the buffer read port and the
// downstream handshake; head word is presented combinationally on o_data.
module coe_buf_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/coe_buf_rd_ctrl.sv
// Read-side controller for the 64x512 coefficient buffer: streams one TU over valid/ready.
// Optional coded-block-flag accumulation is built when COE_BUF_RD_CBF_EN is defined.
module coe_buf_rd_ctrl
    import coe_buf_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = PIXEL_WIDTH * 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        tu_size_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              b_re_o,
    output logic [ADDR_W-1:0] b_addr_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              coe_valid_o,
    input  logic              coe_ready_i,
    output logic [DATA_W-1:0] coe_data_o,
    output logic              coe_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cbf_o,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [1:0]        r_tu_size;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_rd_cnt;
    logic [IDX_W-1:0]  r_out_cnt;
    logic              r_inflight;

    logic              w_start;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [OCC_W-1:0]  w_occupancy;
    logic [IDX_W-1:0]  w_last_idx;
    logic              w_drain_done;

    // Handshake: a word moves when coe_valid_o & coe_ready_i; while valid & !ready the
    // FIFO head (data) and the output counter (last) cannot change, and valid only drops by a pop.
    assign w_last_idx  = tu_last_idx(r_tu_size);
    assign w_start     = start_i && (r_state == ST_IDLE);
    assign coe_valid_o = !w_fifo_empty;
    assign w_pop       = coe_valid_o && coe_ready_i;
    assign coe_last_o  = coe_valid_o && (r_out_cnt == w_last_idx);
    assign w_push      = r_inflight && !w_fifo_full;

    // A word leaving this cycle frees its slot, so a depth-2 FIFO sustains one word per cycle.
    assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue     = (r_state == ST_READ) && (w_occupancy < OCC_W'(FIFO_DEPTH));
    assign b_re_o      = w_issue;
    assign b_addr_o    = w_issue ? (r_base + ADDR_W'(r_rd_cnt)) : '0;

    assign w_drain_done = !r_inflight &&
                          (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));

    always_comb begin
        w_next_state = r_state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                busy_o = 1'b1;
                if (w_issue && (r_rd_cnt == w_last_idx)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (w_drain_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign dbg_state_o = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tu_size  <= '0;
            r_base     <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            if (w_start) begin
                r_tu_size <= tu_size_i;
                r_base    <= base_addr_i;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + IDX_W'(1);
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt + IDX_W'(1);
                end
            end
        end
    end

    coe_buf_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (b_data_i),
        .o_data  (coe_data_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef COE_BUF_RD_CBF_EN
    logic r_cbf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cbf <= 1'b0;
        end else if (w_start) begin
            r_cbf <= 1'b0;
        end else if (w_pop && (|coe_data_o)) begin
            r_cbf <= 1'b1;
        end
    end

    assign cbf_o = done_o && r_cbf;
`else
    assign cbf_o = 1'b1;
`endif

endmodule

// File: tb/tb_coe_buf_rd_ctrl.sv
// Bench for coe_buf_rd_ctrl: behavioural 1-cycle-latency RAM (data[a]=a), TU-level
// reference model with expected queues, per-cycle compare process and directed checks.
module tb_coe_buf_rd_ctrl;
    import coe_buf_rd_ctrl_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = PIXEL_WIDTH * 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [1:0]        tu_size_i = '0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic              b_re_o;
    logic [ADDR_W-1:0] b_addr_o;
    logic [DATA_W-1:0] b_data_i;
    logic              coe_valid_o;
    logic              coe_ready_i = 1'b1;
    logic [DATA_W-1:0] coe_data_o;
    logic              coe_last_o;
    logic              busy_o;
    logic              done_o;
    logic              cbf_o;
    logic [1:0]        dbg_state_o;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    coe_buf_rd_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .tu_size_i   (tu_size_i),
        .base_addr_i (base_addr_i),
        .b_re_o      (b_re_o),
        .b_addr_o    (b_addr_o),
        .b_data_i    (b_data_i),
        .coe_valid_o (coe_valid_o),
        .coe_ready_i (coe_ready_i),
        .coe_data_o  (coe_data_o),
        .coe_last_o  (coe_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cbf_o       (cbf_o),
        .dbg_state_o (dbg_state_o)
    );

    logic [DATA_W-1:0] ram [512];
    always @(posedge clk) begin
        if (b_re_o) b_data_i <= ram[b_addr_o];
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic              m_acc  = 1'b0;
    logic              stall_hold = 1'b0;
    logic [DATA_W-1:0] h_data;
    logic              h_last;

    int                cyc = 0;
    int                start_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    int                xfer_cnt, done_cnt;
    logic              cbf_at_done;
    logic [DATA_W-1:0] out_log[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                addr_cyc_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic cbf_expected(input logic acc);
`ifdef COE_BUF_RD_CBF_EN
        return acc;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- compare process + reference model ----------------
    always @(negedge clk) begin
        logic              cur_busy, cur_done, next_done;
        logic [DATA_W-1:0] e;
        logic              l;
        logic [ADDR_W-1:0] a;
        int                n;
        cyc++;
        if (!rst_n) begin
            chk("rst_valid", coe_valid_o, 0);
            chk("rst_re", b_re_o, 0);
            chk("rst_addr", b_addr_o, 0);
            chk("rst_data", coe_data_o, 0);
            chk("rst_last", coe_last_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_state", dbg_state_o, 0);
`ifdef COE_BUF_RD_CBF_EN
            chk("rst_cbf", cbf_o, 0);
`endif
            exp_q.delete();
            exp_last_q.delete();
            exp_addr_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_acc = 1'b0;
            stall_hold = 1'b0;
        end else begin
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            if (m_done) begin
                chk("cbf", cbf_o, cbf_expected(m_acc));
                chk("tu_complete", exp_q.size() + exp_addr_q.size(), 0);
                cbf_at_done = cbf_o;
            end
            chk("fifo_push_full", dut.r_inflight && dut.w_fifo_full, 0);
            if (b_re_o) begin
                addr_log.push_back(b_addr_o);
                addr_cyc_log.push_back(cyc);
                if (exp_addr_q.size() == 0) chk("b_re_extra", b_re_o, 0);
                else chk("b_addr", b_addr_o, exp_addr_q.pop_front());
            end
            if (stall_hold) begin
                chk("hold_valid", coe_valid_o, 1);
                chk("hold_data", coe_data_o, h_data);
                chk("hold_last", coe_last_o, h_last);
            end
            if (coe_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            next_done = 1'b0;
            if (coe_valid_o && coe_ready_i) begin
                out_log.push_back(coe_data_o);
                if (xfer_cnt == 0) first_xfer_cyc = cyc;
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", coe_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    chk("coe_data", coe_data_o, e);
                    chk("coe_last", coe_last_o, l);
                    m_acc = m_acc | (|e);
                    next_done = l;
                end
            end
            stall_hold = coe_valid_o && !coe_ready_i;
            h_data = coe_data_o;
            h_last = coe_last_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            cur_busy = m_busy;
            cur_done = m_done;
            m_done = next_done;
            if (next_done) m_busy = 1'b0;
            if (start_i && !cur_busy && !cur_done) begin
                n = ((4 << tu_size_i) * (4 << tu_size_i)) / 8;
                for (int i = 0; i < n; i++) begin
                    a = base_addr_i + ADDR_W'(i);
                    exp_addr_q.push_back(a);
                    exp_q.push_back(ram[a]);
                    exp_last_q.push_back(i == n - 1);
                end
                m_busy = 1'b1;
                m_acc = 1'b0;
                start_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_tu(input logic [1:0] size, input logic [ADDR_W-1:0] base);
        @(posedge clk);
        #1;
        first_valid_cyc = -1;
        xfer_cnt = 0;
        done_cnt = 0;
        out_log.delete();
        addr_log.delete();
        addr_cyc_log.delete();
        start_i = 1'b1;
        tu_size_i = size;
        base_addr_i = base;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, input int restart_at);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            #1;
            if (rand_ready) coe_ready_i = 1'($urandom_range(0, 1));
            if (k == restart_at) begin
                start_i = 1'b1;
                tu_size_i = 2'd0;
                base_addr_i = 9'h055;
            end else begin
                start_i = 1'b0;
            end
            k++;
        end
        if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
        start_i = 1'b0;
        coe_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int k;
        for (int a = 0; a < 512; a++) ram[a] = DATA_W'(a);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: 4x4 at 0x010, ready high
        run_tu(2'd0, 9'h010);
        wait_done(100, 1'b0, -1);
        chk("t1_addr0", addr_log[0], 9'h010);
        chk("t1_addr1", addr_log[1], 9'h011);
        chk("t1_addr_consecutive", addr_cyc_log[1] - addr_cyc_log[0], 1);
        chk("t1_word0", out_log[0], 64'h010);
        chk("t1_word1", out_log[1], 64'h011);
        chk("t1_words", xfer_cnt, 2);
        chk("t1_first_valid_latency", first_valid_cyc - start_cyc, 3);
        chk("t1_done_after_last", done_cyc - last_xfer_cyc, 1);

        // 2: 32x32 at 0x1C0 wrapping past 0x1FF
        run_tu(2'd3, 9'h1C0);
        wait_done(400, 1'b0, -1);
        chk("t2_words", xfer_cnt, 128);
        chk("t2_no_bubbles", last_xfer_cyc - first_xfer_cyc, 127);
        chk("t2_addr_1ff", addr_log[63], 9'h1FF);
        chk("t2_addr_wrap", addr_log[64], 9'h000);
        chk("t2_last_word", out_log[127], 64'h03F);

        // 3: 8x8 with random back-pressure
        run_tu(2'd1, 9'h123);
        wait_done(400, 1'b1, -1);
        chk("t3_words", xfer_cnt, 8);
        chk("t3_first_word", out_log[0], 64'h123);
        chk("t3_last_word", out_log[7], 64'h12A);

        // 4: 16x16 with a second start mid-TU
        run_tu(2'd2, 9'h0A0);
        wait_done(400, 1'b0, 10);
        chk("t4_words", xfer_cnt, 32);
        chk("t4_single_done", done_cnt, 1);
        chk("t4_last_word", out_log[31], 64'h0BF);

        // 5: reset at word 5 of an 8x8, then a fresh 4x4
        run_tu(2'd1, 9'h080);
        k = 0;
        while (xfer_cnt < 5 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t5_reached_word5", xfer_cnt, 5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_tu(2'd0, 9'h020);
        wait_done(100, 1'b0, -1);
        chk("t5_words", xfer_cnt, 2);
        chk("t5_word0", out_log[0], 64'h020);
        chk("t5_word1", out_log[1], 64'h021);

        // 6: coded-block flag on an all-zero region, then with one non-zero word
        ram[9'h100] = '0;
        ram[9'h101] = '0;
        run_tu(2'd0, 9'h100);
        wait_done(100, 1'b0, -1);
`ifdef COE_BUF_RD_CBF_EN
        chk("t6_cbf_zero", cbf_at_done, 0);
`else
        chk("t6_cbf_zero", cbf_at_done, 1);
`endif
        ram[9'h101] = 64'h1;
        run_tu(2'd0, 9'h100);
        wait_done(100, 1'b0, -1);
        chk("t6_cbf_one", cbf_at_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
